// File: rtl/display_pkg.sv
// Shared glyph geometry, render FSM state type and glyph row extraction for the sprite renderer.
package display_pkg;

    localparam int GLYPH_ROWS = 5;
    localparam int GLYPH_COLS = 3;
    localparam int HALF_GAP   = 2;
    localparam int HALF_W     = GLYPH_ROWS * GLYPH_COLS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        SWAP  = 2'd3
    } state_t;

    // Row 0 is the top of the glyph and sits in the most significant three bits of a half.
    function automatic logic [GLYPH_COLS-1:0] half_row(input logic [HALF_W-1:0] half,
                                                       input logic [2:0] g);
        logic [HALF_W-1:0] shifted;
        shifted = half >> (GLYPH_COLS * (GLYPH_ROWS - 1 - int'(g)));
        return shifted[GLYPH_COLS-1:0];
    endfunction

endpackage

// File: rtl/letter_stuff.sv
// Letter code to two 3x5 glyph halves; unknown codes render blank.
module letter_stuff
    import display_pkg::*;
(
    input  logic [7:0]        letter_i,
    output logic [HALF_W-1:0] left_o,
    output logic [HALF_W-1:0] right_o
);

    always_comb begin
        left_o  = '0;
        right_o = '0;
        case (letter_i)
            8'h41: begin left_o = 15'b011_100_111_100_100; right_o = 15'b110_001_111_001_001; end
            8'h42: begin left_o = 15'b111_100_111_100_111; right_o = 15'b110_001_110_001_110; end
            8'h43: begin left_o = 15'b011_100_100_100_011; right_o = 15'b111_000_000_000_111; end
            8'h45: begin left_o = 15'b111_100_111_100_111; right_o = 15'b111_000_110_000_111; end
            8'h48: begin left_o = 15'b100_100_111_100_100; right_o = 15'b001_001_111_001_001; end
            8'h4C: begin left_o = 15'b100_100_100_100_111; right_o = 15'b000_000_000_000_111; end
            8'h4F: begin left_o = 15'b011_100_100_100_011; right_o = 15'b110_001_001_001_110; end
            8'h58: begin left_o = 15'b100_010_001_010_100; right_o = 15'b001_010_100_010_001; end
            default: begin left_o = '0; right_o = '0; end
        endcase
    end

endmodule

// File: rtl/sprite_renderer.sv
// Double-buffered sprite renderer: clears a back buffer, ORs one glyph row per cycle into it,
// then publishes the whole frame to framebuffer in a single cycle.
module sprite_renderer
    import display_pkg::*;
#(
    parameter int WIDTH    = 40,
    parameter int HEIGHT   = 30,
    parameter int CHANNELS = 3,
    parameter int YW       = 5,
    parameter int X_BASE   = 6,
    parameter int X_PITCH  = 10,
    parameter int Y_OFFSET = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHANNELS*8-1:0]     letters,
    input  logic [CHANNELS*YW-1:0]    ypos,
    input  logic [CHANNELS-1:0]       enable,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   framebuffer
);

    localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RTW = YW + 2;

    state_t                       state_q;
    logic [RW-1:0]                row_q;
    logic [CW-1:0]                chan_q;
    logic [2:0]                   grow_q;
    logic [CHANNELS-1:0][7:0]     letters_q;
    logic [CHANNELS-1:0][YW-1:0]  ypos_q;
    logic [CHANNELS-1:0]          enable_q;
    logic [WIDTH-1:0]             back_q [HEIGHT];
    logic                         busy_q;
    logic                         done_q;
    logic [WIDTH*HEIGHT-1:0]      fb_q;

    logic [HALF_W-1:0]            left_half;
    logic [HALF_W-1:0]            right_half;
    logic [GLYPH_COLS-1:0]        left_bits;
    logic [GLYPH_COLS-1:0]        right_bits;
    logic [RTW-1:0]               target_row;
    logic                         row_hit;
    logic [WIDTH-1:0]             row_mask;
    int                           x_left;

    // One glyph lookup serves every channel; the channel counter selects whose letter it sees.
    letter_stuff u_glyph (
        .letter_i (letters_q[chan_q]),
        .left_o   (left_half),
        .right_o  (right_half)
    );

    always_comb begin
        left_bits  = half_row(left_half, grow_q);
        right_bits = half_row(right_half, grow_q);
        target_row = RTW'(Y_OFFSET) + RTW'(ypos_q[chan_q]) + RTW'(grow_q);
        row_hit    = enable_q[chan_q] && (32'(target_row) < 32'(HEIGHT));
        x_left     = X_BASE + int'(chan_q) * X_PITCH;
        row_mask   = '0;
        // Columns past the right edge simply never match, which drops those pixels.
        for (int x = 0; x < WIDTH; x++) begin
            int off;
            off = x - x_left;
            if (off >= 0 && off < GLYPH_COLS) begin
                row_mask[x] = left_bits[off];
            end else if (off >= GLYPH_COLS + HALF_GAP && off < 2 * GLYPH_COLS + HALF_GAP) begin
                row_mask[x] = right_bits[off - GLYPH_COLS - HALF_GAP];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fb_q    <= '0;
            row_q   <= '0;
            chan_q  <= '0;
            grow_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        letters_q <= letters;
                        ypos_q    <= ypos;
                        enable_q  <= enable;
                        row_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end
                CLEAR: begin
                    back_q[row_q] <= '0;
                    if (row_q == RW'(HEIGHT - 1)) begin
                        chan_q  <= '0;
                        grow_q  <= '0;
                        state_q <= DRAW;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                DRAW: begin
                    if (row_hit) begin
                        back_q[target_row[RW-1:0]] <= back_q[target_row[RW-1:0]] | row_mask;
                    end
                    if (grow_q == 3'(GLYPH_ROWS - 1)) begin
                        grow_q <= '0;
                        if (chan_q == CW'(CHANNELS - 1)) begin
                            state_q <= SWAP;
                        end else begin
                            chan_q <= chan_q + 1'b1;
                        end
                    end else begin
                        grow_q <= grow_q + 1'b1;
                    end
                end
                SWAP: begin
                    for (int r = 0; r < HEIGHT; r++) begin
                        fb_q[r*WIDTH +: WIDTH] <= back_q[r];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign framebuffer = fb_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: three parameterisations run in lockstep against a pixel-level model.
module tb_sprite_renderer;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [23:0]   letters;
    logic [14:0]   ypos;
    logic [2:0]    enable;

    logic          busy_def, done_def, busy_clip, done_clip, busy_ovl, done_ovl;
    logic [1199:0] fb_def, fb_ovl;
    logic [479:0]  fb_clip;
    logic [1199:0] exp_def, exp_ovl;
    logic [479:0]  exp_clip;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sprite_renderer u_def (
        .clock(clock), .reset(reset), .start(start), .letters(letters), .ypos(ypos),
        .enable(enable), .busy(busy_def), .done(done_def), .framebuffer(fb_def)
    );

    sprite_renderer #(.WIDTH(16), .X_BASE(12), .X_PITCH(10)) u_clip (
        .clock(clock), .reset(reset), .start(start), .letters(letters), .ypos(ypos),
        .enable(enable), .busy(busy_clip), .done(done_clip), .framebuffer(fb_clip)
    );

    sprite_renderer #(.X_PITCH(0)) u_ovl (
        .clock(clock), .reset(reset), .start(start), .letters(letters), .ypos(ypos),
        .enable(enable), .busy(busy_ovl), .done(done_ovl), .framebuffer(fb_ovl)
    );

    // Glyph table: {left half, right half}, each half five rows of three bits, top row first.
    function automatic logic [29:0] glyph(input logic [7:0] code);
        case (code)
            8'h41: return {15'b011_100_111_100_100, 15'b110_001_111_001_001};
            8'h42: return {15'b111_100_111_100_111, 15'b110_001_110_001_110};
            8'h43: return {15'b011_100_100_100_011, 15'b111_000_000_000_111};
            8'h45: return {15'b111_100_111_100_111, 15'b111_000_110_000_111};
            8'h48: return {15'b100_100_111_100_100, 15'b001_001_111_001_001};
            8'h4C: return {15'b100_100_100_100_111, 15'b000_000_000_000_111};
            8'h4F: return {15'b011_100_100_100_011, 15'b110_001_001_001_110};
            8'h58: return {15'b100_010_001_010_100, 15'b001_010_100_010_001};
            default: return '0;
        endcase
    endfunction

    // Paint every lit glyph pixel at its screen position, dropping off-screen ones.
    function automatic logic [1199:0] model(input int w, input int h, input int xb, input int xp,
                                           input logic [23:0] lt, input logic [14:0] yp,
                                           input logic [2:0] en);
        logic [1199:0] fb;
        logic [29:0]   gl;
        int            x0, r;
        fb = '0;
        for (int c = 0; c < 3; c++) begin
            if (en[c]) begin
                gl = glyph(lt[8*c +: 8]);
                x0 = xb + c * xp;
                for (int g = 0; g < 5; g++) begin
                    r = 2 + int'(yp[5*c +: 5]) + g;
                    if (r < h) begin
                        for (int k = 0; k < 3; k++) begin
                            if (gl[27 - 3*g + k] && (x0 + k) < w) fb[r*w + x0 + k] = 1'b1;
                            if (gl[12 - 3*g + k] && (x0 + 5 + k) < w) fb[r*w + x0 + 5 + k] = 1'b1;
                        end
                    end
                end
            end
        end
        return fb;
    endfunction

    task automatic compute_expected(input logic [23:0] lt, input logic [14:0] yp, input logic [2:0] en);
        logic [1199:0] tmp;
        exp_def  = model(40, 30, 6, 10, lt, yp, en);
        tmp      = model(16, 30, 12, 10, lt, yp, en);
        exp_clip = tmp[479:0];
        exp_ovl  = model(40, 30, 6, 0, lt, yp, en);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (done_def !== 1'b1 && cycles < 200);
        if (done_def !== 1'b1) cycles = -1;
    endtask

    function automatic logic [7:0] rand_letter();
        logic [7:0] codes [8];
        int         pick;
        codes = '{8'h41, 8'h42, 8'h43, 8'h45, 8'h48, 8'h4C, 8'h4F, 8'h58};
        pick = $urandom_range(0, 9);
        if (pick < 8) return codes[pick];
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic randomize_inputs();
        letters = {rand_letter(), rand_letter(), rand_letter()};
        ypos    = 15'($urandom_range(0, 32767));
        enable  = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        int activity;
        reset = 1'b1; start = 1'b0; letters = '0; ypos = '0; enable = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (fb_def !== '0 || fb_clip !== '0 || fb_ovl !== '0) begin
            n_fail++;
            $display("FAIL reset_fb: got %h expected 0", fb_def);
        end
        n_checks++;
        if ({busy_def, busy_clip, busy_ovl, done_def, done_clip, done_ovl} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy_def, busy_clip, busy_ovl, done_def, done_clip, done_ovl});
        end
        activity = 0;
        repeat (100) begin
            tick();
            if (done_def !== 1'b0 || busy_def !== 1'b0 || fb_def !== '0) activity++;
        end
        n_checks++;
        if (activity != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", activity);
        end
    endtask

    task automatic test_single();
        int cyc;
        letters = {8'h00, 8'h00, 8'h4C};
        ypos    = '0;
        enable  = 3'b001;
        compute_expected(letters, ypos, enable);
        start_frame();
        n_checks++;
        if (busy_def !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b expected 1", busy_def);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 46 || done_clip !== 1'b1 || done_ovl !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles expected 46", cyc);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL single_fb: got %h expected %h", fb_def, exp_def);
        end
        n_checks++;
        if (busy_def !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_fall: got %b expected 0", busy_def);
        end
        tick();
        n_checks++;
        if (done_def !== 1'b0 || fb_def !== exp_def) begin
            n_fail++;
            $display("FAIL single_hold: got done=%b expected done=0 with frame held", done_def);
        end
    endtask

    task automatic test_bottom_clip();
        int cyc;
        letters = {8'h00, 8'h48, 8'h00};
        ypos    = {5'd0, 5'd27, 5'd0};
        enable  = 3'b010;
        compute_expected(letters, ypos, enable);
        start_frame();
        wait_done(cyc);
        n_checks++;
        if (cyc != 46) begin
            n_fail++;
            $display("FAIL bottom_latency: got %0d expected 46", cyc);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL bottom_fb: got %h expected %h", fb_def, exp_def);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        letters = {8'h41, 8'h4F, 8'h58};
        ypos    = {5'd3, 5'd12, 5'd20};
        enable  = 3'b111;
        compute_expected(letters, ypos, enable);
        start_frame();
        randomize_inputs();
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc + 10 != 46) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 46", cyc + 10);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL ignore_fb: got %h expected %h", fb_def, exp_def);
        end
        randomize_inputs();
        compute_expected(letters, ypos, enable);
        start_frame();
        n_checks++;
        if (done_def !== 1'b0 || busy_def !== 1'b1) begin
            n_fail++;
            $display("FAIL second_start: got done=%b busy=%b expected done=0 busy=1", done_def, busy_def);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 46) begin
            n_fail++;
            $display("FAIL second_latency: got %0d expected 46", cyc);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL second_fb: got %h expected %h", fb_def, exp_def);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            compute_expected(letters, ypos, enable);
            start_frame();
            wait_done(cyc);
            n_checks++;
            if (cyc != 46 || fb_def !== exp_def) begin
                n_fail++;
                $display("FAIL rand_def[%0d]: got %0d cycles fb %h expected 46 fb %h", i, cyc, fb_def, exp_def);
            end
            n_checks++;
            if (fb_clip !== exp_clip) begin
                n_fail++;
                $display("FAIL rand_clip[%0d]: got %h expected %h", i, fb_clip, exp_clip);
            end
            n_checks++;
            if (fb_ovl !== exp_ovl) begin
                n_fail++;
                $display("FAIL rand_ovl[%0d]: got %h expected %h", i, fb_ovl, exp_ovl);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        randomize_inputs();
        enable = 3'b111;
        compute_expected(letters, ypos, enable);
        start = 1'b1;
        tick();
        wait_done(cyc);
        n_checks++;
        if (cyc != 46 || fb_def !== exp_def || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d cycles fb %h expected 46 fb %h", cyc, fb_def, exp_def);
        end
        randomize_inputs();
        enable = 3'b111;
        compute_expected(letters, ypos, enable);
        tick();
        wait_done(cyc);
        start = 1'b0;
        n_checks++;
        if (cyc + 1 != 47) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d expected 47", cyc + 1);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", fb_def, exp_def);
        end
        tick();
    endtask

    task automatic test_overlap_reset();
        int cyc;
        int dones;
        letters = {8'h00, 8'h58, 8'h4F};
        ypos    = {5'd0, 5'd10, 5'd10};
        enable  = 3'b011;
        compute_expected(letters, ypos, enable);
        start_frame();
        wait_done(cyc);
        n_checks++;
        if (cyc != 46 || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL overlap_or: got %h expected %h", fb_ovl, exp_ovl);
        end
        n_checks++;
        if (fb_def !== exp_def || fb_clip !== exp_clip) begin
            n_fail++;
            $display("FAIL overlap_side: got %h expected %h", fb_def, exp_def);
        end
        start_frame();
        repeat (19) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (fb_def !== '0 || fb_clip !== '0 || fb_ovl !== '0 || busy_def !== 1'b0 || done_def !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got busy=%b done=%b fb %h expected all 0", busy_def, done_def, fb_def);
        end
        reset = 1'b0;
        dones = 0;
        repeat (60) begin
            tick();
            if (done_def === 1'b1 || done_ovl === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0 || fb_ovl !== '0) begin
            n_fail++;
            $display("FAIL midreset_nodone: got %0d dones expected 0", dones);
        end
        compute_expected(letters, ypos, enable);
        start_frame();
        wait_done(cyc);
        n_checks++;
        if (cyc != 46 || fb_ovl !== exp_ovl) begin
            n_fail++;
            $display("FAIL after_reset: got %0d cycles expected 46", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bottom_clip();
        test_busy_ignore();
        test_random();
        test_back_to_back();
        test_overlap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
